weighted_rr_arbiter: RTL and testbench



---
 rtl/weighted_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_weighted_rr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each turn grants a port up to weight+1 beats,
// then rotates to the next requester without an idle bubble.
module weighted_rr_arbiter #(
  parameter int    PORTS        = 4,
  parameter int    WEIGHT_WIDTH = 4,
  parameter string BEAT         = "CYCLE",
  parameter string LSB_PRIORITY = "HIGH"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded
);

  localparam int IW         = $clog2(PORTS);
  localparam bit ACK_MODE   = (BEAT == "ACKNOWLEDGE");
  localparam bit HIGH_FIRST = (LSB_PRIORITY == "HIGH");

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                  state;
  logic [WEIGHT_WIDTH-1:0] weight_arr [PORTS];
  logic [PORTS-1:0]        mask_reg, mask_next;
  logic [WEIGHT_WIDTH-1:0] credit_reg, credit_next;
  logic [PORTS-1:0]        grant_next;
  logic                    valid_next;
  logic [IW-1:0]           enc_next;
  logic                    req_g, ack_g, beat, release_now, arbitrate;
  logic [PORTS-1:0]        masked_req, other_req, cand;
  logic [IW-1:0]           win;

  generate
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_weight
      assign weight_arr[gi] = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endgenerate

  assign state = grant_valid ? GRANTED : IDLE;

  // Highest-priority set bit of v in the configured tie-break order.
  function automatic logic [IW-1:0] pick(input logic [PORTS-1:0] v);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (HIGH_FIRST) begin
        if (v[PORTS-1-i]) r = IW'(PORTS-1-i);
      end else if (v[i]) begin
        r = IW'(i);
      end
    end
    return r;
  endfunction

  always_comb begin
    req_g       = request[grant_encoded];
    ack_g       = acknowledge[grant_encoded];
    beat        = ACK_MODE ? ack_g : req_g;
    release_now = 1'b0;
    if (state == GRANTED) begin
      if (ACK_MODE) release_now = ack_g && ((credit_reg == '0) || !req_g);
      else          release_now = !req_g || (credit_reg == '0);
    end
    arbitrate = (state == IDLE) || release_now;

    // The releasing port only wins again when nobody else is asking.
    masked_req = request & mask_reg;
    other_req  = request & ~(grant & {PORTS{release_now}});
    if (|masked_req)     cand = masked_req;
    else if (|other_req) cand = other_req;
    else                 cand = request;
    win = pick(cand);

    mask_next   = mask_reg;
    credit_next = credit_reg;
    grant_next  = grant;
    valid_next  = grant_valid;
    enc_next    = grant_encoded;

    if (arbitrate) begin
      if (|request) begin
        grant_next      = '0;
        grant_next[win] = 1'b1;
        valid_next      = 1'b1;
        enc_next        = win;
        credit_next     = weight_arr[win];
        for (int j = 0; j < PORTS; j++) begin
          mask_next[j] = HIGH_FIRST ? (j > int'(win)) : (j < int'(win));
        end
      end else begin
        grant_next = '0;
        valid_next = 1'b0;
        enc_next   = '0;
      end
    end else if ((state == GRANTED) && beat) begin
      // A held beat implies credit_reg is nonzero, so this cannot wrap.
      credit_next = credit_reg - WEIGHT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      mask_reg      <= '0;
      credit_reg    <= '0;
    end else begin
      grant         <= grant_next;
      grant_valid   <= valid_next;
      grant_encoded <= enc_next;
      mask_reg      <= mask_next;
      credit_reg    <= credit_next;
    end
  end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: one CYCLE and one ACKNOWLEDGE instance share
// stimulus and are checked every cycle against a rotating-pointer model.
module tb_weighted_rr_arbiter;

  localparam int PORTS = 4;
  localparam int WW    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [PORTS-1:0]  request = '0;
  logic [PORTS-1:0]  acknowledge = '0;
  logic [PORTS*WW-1:0] weight = '0;

  logic [PORTS-1:0]  grant_c, grant_a;
  logic              valid_c, valid_a;
  logic [1:0]        enc_c, enc_a;

  int tests = 0;
  int fails = 0;

  weighted_rr_arbiter #(.PORTS(PORTS), .WEIGHT_WIDTH(WW), .BEAT("CYCLE"), .LSB_PRIORITY("HIGH")) dut_c (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(grant_c), .grant_valid(valid_c), .grant_encoded(enc_c));

  weighted_rr_arbiter #(.PORTS(PORTS), .WEIGHT_WIDTH(WW), .BEAT("ACKNOWLEDGE"), .LSB_PRIORITY("HIGH")) dut_a (
    .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge), .weight(weight),
    .grant(grant_a), .grant_valid(valid_a), .grant_encoded(enc_a));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = CYCLE instance, 1 = ACKNOWLEDGE instance. A turn is a
  // count of beats used against an allowance; the next winner is the first
  // requester found scanning cyclically upward from the last winner.
  bit m_valid [2];
  int m_g     [2];
  int m_last  [2];
  int m_used  [2];
  int m_allow [2];

  always @(posedge clk or negedge rst_n) begin
    int g, last, used, allow, p;
    bit valid, rel;
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_valid[m] <= 1'b0;
        m_g[m]     <= 0;
        m_last[m]  <= PORTS - 1;
        m_used[m]  <= 0;
        m_allow[m] <= 1;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        valid = m_valid[m]; g = m_g[m]; last = m_last[m];
        used = m_used[m]; allow = m_allow[m]; rel = 1'b0;
        if (valid) begin
          if (m == 0) begin
            if (!request[g]) rel = 1'b1;
            else begin
              used++;
              if (used == allow) rel = 1'b1;
            end
          end else if (acknowledge[g]) begin
            used++;
            if (used == allow || !request[g]) rel = 1'b1;
          end
        end
        if (!valid || rel) begin
          valid = 1'b0;
          for (int k = 1; k <= PORTS; k++) begin
            p = (last + k) % PORTS;
            if (!valid && request[p]) begin
              valid = 1'b1; g = p; last = p; used = 0;
              allow = int'(weight[p*WW +: WW]) + 1;
            end
          end
        end
        m_valid[m] <= valid; m_g[m] <= g; m_last[m] <= last;
        m_used[m]  <= used;  m_allow[m] <= allow;
      end
    end
  end

  function automatic logic [31:0] model_vec(input int m);
    logic [3:0] gr;
    logic [1:0] en;
    gr = '0; en = '0;
    if (m_valid[m]) begin
      gr[m_g[m]] = 1'b1;
      en = 2'(m_g[m]);
    end
    return {25'd0, gr, m_valid[m], en};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #3;
      check("model_cycle", {25'd0, grant_c, valid_c, enc_c}, model_vec(0));
      check("model_ack",   {25'd0, grant_a, valid_a, enc_a}, model_vec(1));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; request = '0; acknowledge = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset behaviour
    request = 4'b1111;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant_c), 32'(0));
    check("rst_valid", 32'(valid_c), 32'(0));
    check("rst_enc",   32'(enc_c),   32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant_c", 32'(grant_c), 32'(4'b0001));
    check("first_grant_a", 32'(grant_a), 32'(4'b0001));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_grant_c", 32'(grant_c), 32'(0));
    check("midrst_valid_c", 32'(valid_c), 32'(0));
    check("midrst_grant_a", 32'(grant_a), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Plain round robin
    do_reset();
    weight = '0; request = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(grant_c), (k % 2 == 0) ? 32'(4'b0001) : 32'(4'b0100));
      check("rr_valid", 32'(valid_c), 32'(1));
    end

    // Weighted shares 0,0,0,2
    do_reset();
    weight = 16'h0002; request = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("wt_enc",   32'(enc_c),   (k % 4 == 3) ? 32'(2) : 32'(0));
      check("wt_model", 32'(m_g[0]),  (k % 4 == 3) ? 32'(2) : 32'(0));
    end

    // Maximum weight: 16 beats for port 2, no underflow
    do_reset();
    weight = 16'h0F00; request = 4'b0110;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("maxw_grant", 32'(grant_c), (k == 0 || k == 17) ? 32'(4'b0010) : 32'(4'b0100));
    end

    // Acknowledge hold and release
    do_reset();
    weight = 16'h0010; request = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("ack_hold", 32'(grant_a), 32'(4'b0010));
    end
    acknowledge = 4'b0010;
    @(negedge clk);
    acknowledge = 4'b0000;
    check("ack_first_pulse", 32'(grant_a), 32'(4'b0010));
    request = 4'b0011; acknowledge = 4'b0010;
    @(negedge clk);
    acknowledge = 4'b0000;
    check("ack_release_grant", 32'(grant_a), 32'(4'b0001));
    check("ack_release_enc",   32'(enc_a),   32'(0));

    // Early drop with fresh credit on the next turn
    do_reset();
    weight = 16'h0070; request = 4'b1010;
    @(negedge clk);
    check("drop_c1", 32'(grant_c), 32'(4'b0010));
    @(negedge clk);
    check("drop_c2", 32'(grant_c), 32'(4'b0010));
    request = 4'b1000;
    @(negedge clk);
    check("drop_to3", 32'(grant_c), 32'(4'b1000));
    request = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("drop_refill", 32'(grant_c), 32'(4'b0010));
    end
    @(negedge clk);
    check("drop_back3", 32'(grant_c), 32'(4'b1000));

    // Sole requester
    do_reset();
    weight = '0; request = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("sole_grant", 32'(grant_c), 32'(4'b1000));
      check("sole_valid", 32'(valid_c), 32'(1));
    end
    request = 4'b0000;
    @(negedge clk);
    check("sole_idle_valid", 32'(valid_c), 32'(0));
    check("sole_idle_enc",   32'(enc_c),   32'(0));
    check("sole_idle_grant", 32'(grant_c), 32'(0));

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
